// File: rtl/n2_pwl_pkg.sv
// Shared constants and fixed-point helpers for the piecewise-linear activation cluster.
// sat_n works on a 64-bit carrier, so it covers data widths up to N=32.
package n2_pwl_pkg;

  localparam logic [1:0] MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MODE_SIG_SYM  = 2'd1;
  localparam logic [1:0] MODE_TANH_SYM = 2'd2;

  localparam int FRAC_DEFAULT = 8;

  function automatic logic signed [63:0] one_fx(input int frac);
    return 64'sd1 <<< frac;
  endfunction

  localparam logic signed [63:0] ONE = one_fx(FRAC_DEFAULT);

  // Clamp v to the signed range of an n-bit word.
  function automatic logic signed [63:0] sat_n(input logic signed [63:0] v, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/n2_pwl_lane.sv
// One lane: segment index, then multiply / add / symmetry fold-back over three registered stages.
module n2_pwl_lane
  import n2_pwl_pkg::*;
#(
  parameter int N        = 16,
  parameter int FRAC     = 8,
  parameter int SEG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        x,
  output logic [SEG_BITS-1:0] idx,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  output logic [N-1:0]        y
);

  localparam logic [N-1:0] MIN_X = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_X = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [63:0] ONE_W = one_fx(FRAC);
  localparam logic signed [N:0]  ONE_N = ONE_W[N:0];

  logic               sym;
  logic [N-1:0]       ax;
  logic [N-1:0]       xd;

  always_comb begin
    sym = (mode == MODE_SIG_SYM) || (mode == MODE_TANH_SYM);
    if (x == MIN_X)   ax = MAX_X;
    else if (x[N-1])  ax = -x;
    else              ax = x;
    xd  = sym ? ax : x;
    idx = sym ? ax[N-2 -: SEG_BITS] : {~x[N-1], x[N-2 -: SEG_BITS-1]};
  end

  logic signed [N-1:0] x1, a1, b1;
  logic                neg1;
  logic [1:0]          mode1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0; a1 <= '0; b1 <= '0; neg1 <= 1'b0; mode1 <= MODE_DIRECT;
    end else if (adv) begin
      x1 <= xd; a1 <= a; b1 <= b; neg1 <= x[N-1]; mode1 <= mode;
    end
  end

  // Arithmetic shift of the full product floors toward -inf before saturating.
  logic signed [2*N-1:0] prod, shifted;
  logic signed [63:0]    pw;
  logic signed [N-1:0]   p_next;

  always_comb begin
    prod    = (2*N)'(a1) * (2*N)'(x1);
    shifted = prod >>> FRAC;
    pw      = sat_n(64'(shifted), N);
    p_next  = pw[N-1:0];
  end

  logic signed [N-1:0] p2, b2;
  logic                neg2;
  logic [1:0]          mode2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2 <= '0; b2 <= '0; neg2 <= 1'b0; mode2 <= MODE_DIRECT;
    end else if (adv) begin
      p2 <= p_next; b2 <= b1; neg2 <= neg1; mode2 <= mode1;
    end
  end

  logic signed [N:0]   sum, se, d;
  logic signed [63:0]  sw, yw;
  logic signed [N-1:0] s;
  logic [N-1:0]        y_next;

  always_comb begin
    sum    = {p2[N-1], p2} + {b2[N-1], b2};
    sw     = sat_n(64'(sum), N);
    s      = sw[N-1:0];
    se     = {s[N-1], s};
    d      = se;
    yw     = '0;
    y_next = s;
    if (neg2 && (mode2 == MODE_SIG_SYM)) begin
      d      = ONE_N - se;
      yw     = sat_n(64'(d), N);
      y_next = yw[N-1:0];
    end else if (neg2 && (mode2 == MODE_TANH_SYM)) begin
      d      = -se;
      yw     = sat_n(64'(d), N);
      y_next = yw[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   y <= '0;
    else if (adv) y <= y_next;
  end

endmodule

// File: rtl/n2_pwl_cluster.sv
// Tn-lane piecewise-linear activation: shared coefficient table, valid pipeline and stall control.
module n2_pwl_cluster
  import n2_pwl_pkg::*;
#(
  parameter int N        = 16,
  parameter int FRAC     = 8,
  parameter int SEG_BITS = 4,
  parameter int Tn       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [1:0]          i_mode,
  input  logic [Tn*N-1:0]     i_X,
  output logic                o_valid,
  input  logic                i_out_ready,
  output logic [Tn*N-1:0]     o_Y,
  input  logic                i_coef_wr,
  input  logic [SEG_BITS-1:0] i_coef_addr,
  input  logic [2*N-1:0]      i_coef_data
);

  localparam int DEPTH = 2**SEG_BITS;

  logic           adv;
  logic           v1, v2, v3;
  logic [2*N-1:0] coef_q [DEPTH];

  assign adv     = !v3 || i_out_ready;
  assign o_ready = adv;
  assign o_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
    end else if (adv) begin
      v1 <= i_valid; v2 <= v1; v3 <= v2;
    end
  end

  // Lanes read the registered table combinationally, so a same-cycle write is seen only by later beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) coef_q[e] <= '0;
    end else if (i_coef_wr) begin
      coef_q[i_coef_addr] <= i_coef_data;
    end
  end

  for (genvar g = 0; g < Tn; g++) begin : g_lane
    logic [SEG_BITS-1:0] idx;
    logic [2*N-1:0]      ent;

    assign ent = coef_q[idx];

    n2_pwl_lane #(.N(N), .FRAC(FRAC), .SEG_BITS(SEG_BITS)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (adv),
      .mode (i_mode),
      .x    (i_X[g*N +: N]),
      .idx  (idx),
      .a    (ent[2*N-1:N]),
      .b    (ent[N-1:0]),
      .y    (o_Y[g*N +: N])
    );
  end

endmodule

// File: tb/tb_n2_pwl_cluster.sv
// Directed bench for n2_pwl_cluster with four lanes and hand-computed expected results.
module tb_n2_pwl_cluster;
  localparam int N = 16, FRAC = 8, SEG_BITS = 4, TN = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_valid = 1'b0;
  logic                o_ready;
  logic [1:0]          i_mode = 2'd0;
  logic [TN*N-1:0]     i_X = '0;
  logic                o_valid;
  logic                i_out_ready = 1'b1;
  logic [TN*N-1:0]     o_Y;
  logic                i_coef_wr = 1'b0;
  logic [SEG_BITS-1:0] i_coef_addr = '0;
  logic [2*N-1:0]      i_coef_data = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  n2_pwl_cluster #(.N(N), .FRAC(FRAC), .SEG_BITS(SEG_BITS), .Tn(TN)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_X(i_X), .o_valid(o_valid), .i_out_ready(i_out_ready), .o_Y(o_Y),
    .i_coef_wr(i_coef_wr), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] x;
    logic [63:0] y;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int addr, input logic [15:0] a, input logic [15:0] b);
    i_coef_wr   = 1'b1;
    i_coef_addr = SEG_BITS'(addr);
    i_coef_data = {a, b};
    step();
    i_coef_wr = 1'b0;
  endtask

  task automatic run_beat(input string name, input logic [1:0] mode, input logic [63:0] x,
                          input logic [63:0] y);
    i_mode = mode; i_X = x; i_valid = 1'b1; i_out_ready = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    check({name, "_early"}, 64'(o_valid), 64'd0);
    step();
    check({name, "_valid"}, 64'(o_valid), 64'd1);
    check({name, "_y"}, o_Y, y);
    step();
    check({name, "_one_cycle"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    int sent, got;
    logic [63:0] held;

    vecs[0] = '{2'd0, {16'h1080, 16'hC000, 16'h7FFF, 16'h0100}, {16'hFFEF, 16'hBF80, 16'h7FFF, 16'h00C0}};
    vecs[1] = '{2'd1, {16'h1800, 16'hE800, 16'h8000, 16'hFF00}, {16'h8000, 16'h7FFF, 16'h8101, 16'h0040}};
    vecs[2] = '{2'd2, {16'h0100, 16'hE800, 16'h8000, 16'hFF00}, {16'h00C0, 16'h7FFF, 16'h8001, 16'hFF40}};
    vecs[3] = '{2'd3, {16'h8000, 16'h1080, 16'hC000, 16'h0100}, {16'hE080, 16'hFFEF, 16'hBF80, 16'h00C0}};
    vecs[4] = '{2'd1, {16'h8001, 16'hFF00, 16'h0100, 16'h0000}, {16'h8101, 16'h0040, 16'h00C0, 16'h0080}};

    #12;
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_y", o_Y, 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 64'(o_ready), 64'd1);
    step();

    wr_coef(0,  16'h0040, 16'h0080);
    wr_coef(3,  16'h0000, 16'h8000);
    wr_coef(4,  16'h0100, 16'hFF80);
    wr_coef(8,  16'h0040, 16'h0080);
    wr_coef(9,  16'hFFFF, 16'h0000);
    wr_coef(15, 16'h7FFF, 16'h7FFF);

    for (int k = 0; k < 5; k++)
      run_beat($sformatf("vec%0d", k), vecs[k].mode, vecs[k].x, vecs[k].y);

    // Streaming with a three-cycle downstream stall.
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      i_out_ready = !(cyc >= 5 && cyc < 8);
      if (sent < 8) begin
        i_valid = 1'b1; i_mode = vecs[sent % 5].mode; i_X = vecs[sent % 5].x;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (cyc == 5) held = o_Y;
      if (cyc >= 5 && cyc < 8) begin
        check($sformatf("stall_ready_c%0d", cyc), 64'(o_ready), 64'd0);
        check($sformatf("stall_hold_c%0d", cyc), o_Y, held);
      end
      if (o_valid && i_out_ready) begin
        check($sformatf("stream_beat%0d", got), o_Y, vecs[got % 5].y);
        got++;
      end
      if (i_valid && o_ready) sent++;
      step();
    end
    i_valid = 1'b0;
    check("stream_count", 64'(got), 64'd8);
    step();
    check("stream_drained", 64'(o_valid), 64'd0);

    // Table write and read of the same entry in one cycle.
    i_out_ready = 1'b1; i_mode = 2'd0; i_X = {4{16'h0100}}; i_valid = 1'b1;
    i_coef_wr = 1'b1; i_coef_addr = 4'd8; i_coef_data = {16'h0000, 16'h0011};
    step();
    i_coef_wr = 1'b0;
    step();
    i_valid = 1'b0;
    step();
    check("collide_old_valid", 64'(o_valid), 64'd1);
    check("collide_old_y", o_Y, {4{16'h00C0}});
    step();
    check("collide_new_valid", 64'(o_valid), 64'd1);
    check("collide_new_y", o_Y, {4{16'h0011}});
    step();
    check("collide_end", 64'(o_valid), 64'd0);

    // Reset with beats in flight.
    i_mode = 2'd0; i_X = {4{16'h0100}}; i_valid = 1'b1;
    step(); step(); step();
    i_valid = 1'b0;
    check("rst_pre_valid", 64'(o_valid), 64'd1);
    check("rst_pre_y", o_Y, {4{16'h0011}});
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(o_valid), 64'd0);
    check("rst_async_y", o_Y, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst_no_beat%0d", c), 64'(o_valid), 64'd0);
    end
    run_beat("rst_table_cleared", 2'd0, {4{16'h0100}}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
